// File: rtl/system_soc_clk_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package system_soc_clk_pkg;

    // Lock/run sequencing states; encoding 2'd3 is unused and recovers to WAIT_LOCK.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } clk_state_t;

    localparam logic [1:0] ST_WAIT_LOCK_ENC = 2'd0;
    localparam logic [1:0] ST_SETTLE_ENC    = 2'd1;
    localparam logic [1:0] ST_RUN_ENC       = 2'd2;

    // Increment word for a target enable rate: f_target * 2^acc_w / f_ref.
    // Intended for stimulus generation; not used by the synthesised logic.
    function automatic longint unsigned calc_inc(input longint unsigned f_target_hz,
                                                 input longint unsigned f_ref_hz,
                                                 input int unsigned     acc_w);
        longint unsigned num;
        num = f_target_hz << acc_w;
        return num / f_ref_hz;
    endfunction

endpackage

// File: rtl/system_soc_clk_en_acc.sv
// One enable channel: phase accumulator, shadow/active increment pair and
// the registered strobe. The active increment only changes at a carry, while
// idle, or on realign, so a retune never shortens a period in flight.
module system_soc_clk_en_acc
    import system_soc_clk_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             en,
    input  logic             realign,
    input  logic             wr,
    input  logic [ACC_W-1:0] inc,
    output logic             strobe
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] act_q, act_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             strobe_q, strobe_d;
    logic [ACC_W:0]   sum_s;

    // Next-state of accumulator, increments and strobe; run low means idle or leaving RUN.
    always_comb begin
        sum_s    = {1'b0, acc_q} + {1'b0, act_q};
        acc_d    = acc_q;
        act_d    = act_q;
        strobe_d = 1'b0;
        if (wr) begin
            shadow_d = inc;
        end else begin
            shadow_d = shadow_q;
        end
        if (!run) begin
            acc_d = '0;
            act_d = shadow_q;
        end else if (realign) begin
            acc_d = '0;
            act_d = shadow_q;
        end else if (!en) begin
            acc_d = acc_q;
            act_d = shadow_q;
        end else begin
            acc_d    = sum_s[ACC_W-1:0];
            strobe_d = sum_s[ACC_W];
            if (sum_s[ACC_W]) begin
                act_d = shadow_q;
            end else begin
                act_d = act_q;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            act_q    <= '0;
            shadow_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/system_soc_clk_en_gen.sv
// Multi-channel fractional clock-enable generator. Owns the PLL-lock
// synchroniser, the lock-debounce FSM and settle counter; each channel's
// accumulator lives in system_soc_clk_en_acc.
module system_soc_clk_en_gen
    import system_soc_clk_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int ACC_W       = 32,
    parameter  int LOCK_CYCLES = 1024,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              pll_locked_in,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              realign,
    output logic [NUM_CH-1:0] clk_en,
    output logic              locked,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             lk_s;
    clk_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             run_s;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked_in;
            sync2_q <= sync1_q;
        end
    end

    assign lk_s = sync2_q;

    // Lock debounce: RUN is entered on the edge the counter reaches LOCK_CYCLES-1,
    // i.e. after LOCK_CYCLES consecutive high samples of lk_s.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lk_s) begin
                    state_d = SETTLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_CYCLES - 2)) begin
                    state_d = RUN;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    state_d = SETTLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        locked_d = (state_d == RUN);
    end

    // FSM state, settle counter and registered lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    // Channels advance only while in RUN and staying there; the exit edge clears them.
    assign run_s   = (state_q == RUN) && lk_s;
    assign locked  = locked_q;
    assign state_o = state_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        system_soc_clk_en_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clk     (refclk),
            .rst_n   (rst_n),
            .run     (run_s),
            .en      (ch_en[i]),
            .realign (realign),
            .wr      (cfg_wr && (cfg_ch == CH_W'(i))),
            .inc     (cfg_inc),
            .strobe  (clk_en[i])
        );
    end

endmodule

// File: tb/tb_system_soc_clk_en_gen.sv
// Self-checking bench for system_soc_clk_en_gen (NUM_CH=4, ACC_W=32, LOCK_CYCLES=16).
module tb_system_soc_clk_en_gen;
    import system_soc_clk_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 32;
    localparam int LOCKC  = 16;

    logic              refclk;
    logic              rst_n;
    logic              pll_locked_in;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] ch_en;
    logic              realign;
    logic [NUM_CH-1:0] clk_en;
    logic              locked;
    logic [1:0]        state_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    system_soc_clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCKC)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked_in (pll_locked_in),
        .cfg_wr        (cfg_wr),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .ch_en         (ch_en),
        .realign       (realign),
        .clk_en        (clk_en),
        .locked        (locked),
        .state_o       (state_o)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [3:0][31:0] inc;
        logic [15:0]      cycles;
        logic [3:0][15:0] exp_cnt;
    } rate_vec_t;

    rate_vec_t vecs [3];

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] required);
        total_cnt++;
        if (actual === required) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic wr_inc(input int ch, input logic [31:0] val);
        cfg_wr  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_inc = val;
        tick();
        cfg_wr  = 1'b0;
    endtask

    task automatic do_realign();
        realign = 1'b1;
        tick();
        realign = 1'b0;
    endtask

    // First four RUN cycles with incs 1/2, 1/4, 0x55555556, 0 from cleared accumulators.
    task automatic chk_first_strobes(input string tag);
        logic [3:0] exp_v [4];
        exp_v[0] = 4'b0000;
        exp_v[1] = 4'b0001;
        exp_v[2] = 4'b0100;
        exp_v[3] = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s_run%0d", tag, k + 1), 64'(clk_en), 64'(exp_v[k]));
        end
    endtask

    initial begin
        logic        bad;
        logic [22:0] exp_mask;
        int          cnt [4];
        int          lock_ticks;
        int          nz;

        vecs[0] = '{inc: {32'h0000_0000, 32'h5555_5556, 32'h4000_0000,
                          32'(calc_inc(64'd25_000_000, 64'd50_000_000, 32))},
                    cycles: 16'd3000,
                    exp_cnt: {16'd0, 16'd1000, 16'd750, 16'd1500}};
        vecs[1] = '{inc: {32'h1000_0000, 32'hC000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
                    cycles: 16'd64,
                    exp_cnt: {16'd4, 16'd48, 16'd0, 16'd63}};
        vecs[2] = '{inc: {32'hFFFF_FFFF, 32'h0800_0000, 32'hAAAA_AAAB, 32'h2000_0000},
                    cycles: 16'd96,
                    exp_cnt: {16'd95, 16'd3, 16'd64, 16'd12}};

        rst_n         = 1'b0;
        pll_locked_in = 1'b0;
        cfg_wr        = 1'b0;
        cfg_ch        = 2'd0;
        cfg_inc       = '0;
        ch_en         = 4'b0000;
        realign       = 1'b0;

        // Reset state
        tick();
        chk("rst_clk_en", 64'(clk_en), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_state", 64'(state_o), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("wait_state", 64'(state_o), 64'd0);

        // Program the rate set while waiting for lock
        ch_en = 4'b1111;
        wr_inc(0, 32'h8000_0000);
        wr_inc(1, 32'h4000_0000);
        wr_inc(2, 32'h5555_5556);
        wr_inc(3, 32'h0000_0000);

        // Lock sequence: locked rises exactly 18 edges after the raw lock rises
        pll_locked_in = 1'b1;
        bad = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (locked || (clk_en != 4'b0000)) bad = 1'b1;
        end
        chk("prelock_quiet", 64'(bad), 64'd0);
        tick();
        chk("lock_edge18", 64'(locked), 64'd1);
        chk("lock_state_run", 64'(state_o), 64'd2);
        chk_first_strobes("first");

        // Lock drop in RUN: exit, strobes and lock cleared
        pll_locked_in = 1'b0;
        tick();
        tick();
        tick();
        chk("drop_locked", 64'(locked), 64'd0);
        chk("drop_clk_en", 64'(clk_en), 64'd0);
        chk("drop_state", 64'(state_o), 64'd0);

        // Lock glitch during SETTLE restarts the debounce
        pll_locked_in = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("glitch_in_settle", 64'(state_o), 64'd1);
        pll_locked_in = 1'b0;
        tick();
        pll_locked_in = 1'b1;
        bad = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 2) chk("glitch_back_wait", 64'(state_o), 64'd0);
            if (locked) bad = 1'b1;
        end
        chk("glitch_prelock", 64'(bad), 64'd0);
        tick();
        chk("glitch_lock_edge18", 64'(locked), 64'd1);
        chk_first_strobes("relock");

        // Retune ch0: 1/4 -> 1/2 mid-period, then 1/2 -> 1/4 coinciding with a carry
        wr_inc(0, 32'h4000_0000);
        do_realign();
        exp_mask = '0;
        exp_mask[4]  = 1'b1;
        exp_mask[8]  = 1'b1;
        exp_mask[10] = 1'b1;
        exp_mask[12] = 1'b1;
        exp_mask[14] = 1'b1;
        exp_mask[18] = 1'b1;
        exp_mask[22] = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            cfg_wr = 1'b0;
            chk($sformatf("retune_c%0d", k), 64'(clk_en[0]), 64'(exp_mask[k]));
            if (k == 5) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 32'h8000_0000;
            end else if (k == 11) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_inc = 32'h4000_0000;
            end else begin
                cfg_wr = 1'b0;
            end
        end
        cfg_wr = 1'b0;

        // Realign re-phases ch0 (1/4) and ch1 (1/8) after drifting ch1
        ch_en = 4'b0011;
        wr_inc(0, 32'h4000_0000);
        wr_inc(1, 32'h2000_0000);
        do_realign();
        for (int k = 0; k < 5; k++) tick();
        ch_en = 4'b0001;
        for (int k = 0; k < 3; k++) tick();
        ch_en = 4'b0011;
        tick();
        tick();
        do_realign();
        chk("realign_edge", 64'(clk_en[1:0]), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("realign_c%0d", k), 64'(clk_en[1:0]),
                (k == 8) ? 64'd3 : ((k == 4) ? 64'd1 : 64'd0));
        end

        // Table-driven rate vectors, each from a realigned start
        for (int v = 0; v < 3; v++) begin
            ch_en = 4'b1111;
            for (int c = 0; c < 4; c++) wr_inc(c, vecs[v].inc[c]);
            do_realign();
            for (int c = 0; c < 4; c++) cnt[c] = 0;
            for (int n = 0; n < int'(vecs[v].cycles); n++) begin
                tick();
                for (int c = 0; c < 4; c++) cnt[c] += int'(clk_en[c]);
            end
            for (int c = 0; c < 4; c++)
                chk($sformatf("rate_v%0d_ch%0d", v, c), 64'(cnt[c]), 64'(vecs[v].exp_cnt[c]));
        end

        // Async reset mid-RUN while a strobe is high
        wr_inc(0, 32'h8000_0000);
        do_realign();
        tick();
        tick();
        chk("prereset_strobe", 64'(clk_en[0]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clk_en", 64'(clk_en), 64'd0);
        chk("async_locked", 64'(locked), 64'd0);
        chk("async_state", 64'(state_o), 64'd0);
        #2;
        rst_n = 1'b1;
        lock_ticks = 0;
        while (!locked && lock_ticks < 40) begin
            tick();
            lock_ticks++;
        end
        chk("post_reset_lock_ticks", 64'(lock_ticks), 64'd18);
        nz = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (clk_en != 4'b0000) nz++;
        end
        chk("post_reset_inc_zero", 64'(nz), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
